// File: rtl/ps2_teclado_rx.sv
// ----------------------------------------------------------------------------
// ps2_teclado_rx
//
// PS/2 keyboard receiver for the game front end. It deserialises 11-bit
// device-to-host frames (start 0, 8 data bits LSB first, odd parity, stop 1)
// and tracks the E0 (extended) and F0 (break) prefixes. It produces
// player-control levels and a start pulse that can replace or be OR-ed with
// the push-button inputs of the game state machines.
//
// Optional build macro:
//   PS2_ARROWS_EN - when defined, the extended left and right arrow keys
//                   (E0 6B, E0 74) drive oIzquierda and oDerecha exactly like
//                   KEY_LEFT and KEY_RIGHT.
//
// Ports:
//   iClk        in   system clock, rising edge
//   iReset      in   asynchronous active-low reset
//   iPs2Clk     in   raw PS/2 clock line (asynchronous)
//   iPs2Data    in   raw PS/2 data line (asynchronous)
//   oScanCode   out  [7:0] last decoded non-prefix scan code
//   oCodeValid  out  one-cycle pulse per decoded non-prefix code
//   oBreak      out  code was preceded by F0 (qualified by oCodeValid)
//   oExtended   out  code was preceded by E0 (qualified by oCodeValid)
//   oIzquierda  out  level, high while KEY_LEFT is held
//   oDerecha    out  level, high while KEY_RIGHT is held
//   oStart      out  one-cycle pulse on the first make of KEY_START
//   oFrameErr   out  one-cycle pulse on parity, stop-bit or timeout error
// ----------------------------------------------------------------------------
module ps2_teclado_rx #(
  parameter int         CLK_HZ     = 50000000,
  parameter int         TIMEOUT_US = 1000,
  parameter logic [7:0] KEY_LEFT   = 8'h1C,
  parameter logic [7:0] KEY_RIGHT  = 8'h23,
  parameter logic [7:0] KEY_START  = 8'h29
) (
  input  logic       iClk,
  input  logic       iReset,
  input  logic       iPs2Clk,
  input  logic       iPs2Data,
  output logic [7:0] oScanCode,
  output logic       oCodeValid,
  output logic       oBreak,
  output logic       oExtended,
  output logic       oIzquierda,
  output logic       oDerecha,
  output logic       oStart,
  output logic       oFrameErr
);

  localparam int unsigned WDOG_LIMIT = (CLK_HZ / 1000000) * TIMEOUT_US;
  localparam int unsigned WDOG_W     = $clog2(WDOG_LIMIT + 1);

  localparam logic [7:0] CODE_EXT   = 8'hE0;
  localparam logic [7:0] CODE_BRK   = 8'hF0;
  localparam logic [7:0] ARROW_LEFT = 8'h6B;
  localparam logic [7:0] ARROW_RIGHT = 8'h74;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_PARITY = 2'd2,
    ST_STOP   = 2'd3
  } state_t;

  // --------------------------------------------------------------------------
  // Input synchronisers and falling-edge detection
  // --------------------------------------------------------------------------
  logic r_ps2clk_s1, r_ps2clk_s2, r_ps2clk_prev;
  logic r_ps2dat_s1, r_ps2dat_s2;
  logic w_fall;
  logic w_ps2dat;

  always_ff @(posedge iClk or negedge iReset) begin
    if (!iReset) begin
      // Lines idle high, so reset to 1 to avoid a false edge after reset.
      r_ps2clk_s1   <= 1'b1;
      r_ps2clk_s2   <= 1'b1;
      r_ps2clk_prev <= 1'b1;
      r_ps2dat_s1   <= 1'b1;
      r_ps2dat_s2   <= 1'b1;
    end else begin
      r_ps2clk_s1   <= iPs2Clk;
      r_ps2clk_s2   <= r_ps2clk_s1;
      r_ps2clk_prev <= r_ps2clk_s2;
      r_ps2dat_s1   <= iPs2Data;
      r_ps2dat_s2   <= r_ps2dat_s1;
    end
  end

  assign w_fall   = r_ps2clk_prev & ~r_ps2clk_s2;
  assign w_ps2dat = r_ps2dat_s2;

  // --------------------------------------------------------------------------
  // Frame FSM: state register / next-state logic / output decode
  // --------------------------------------------------------------------------
  state_t            r_state;
  state_t            w_state_next;
  logic [2:0]        r_bit_cnt;
  logic [7:0]        r_shift;
  logic              r_parity;
  logic [WDOG_W-1:0] r_wdog;

  logic w_start_bit;
  logic w_shift_en;
  logic w_par_en;
  logic w_stop_en;
  logic w_timeout;

  always_ff @(posedge iClk or negedge iReset) begin
    if (!iReset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    if (w_timeout) begin
      w_state_next = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE:   if (w_fall && !w_ps2dat)           w_state_next = ST_DATA;
        ST_DATA:   if (w_fall && (r_bit_cnt == 3'd7)) w_state_next = ST_PARITY;
        ST_PARITY: if (w_fall)                        w_state_next = ST_STOP;
        ST_STOP:   if (w_fall)                        w_state_next = ST_IDLE;
        default:                                      w_state_next = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    w_start_bit = 1'b0;
    w_shift_en  = 1'b0;
    w_par_en    = 1'b0;
    w_stop_en   = 1'b0;
    case (r_state)
      ST_IDLE:   w_start_bit = w_fall & ~w_ps2dat;
      ST_DATA:   w_shift_en  = w_fall;
      ST_PARITY: w_par_en    = w_fall;
      ST_STOP:   w_stop_en   = w_fall;
      default:   ;
    endcase
    // A falling edge in the same cycle as the limit still counts as activity.
    w_timeout = (r_state != ST_IDLE) && !w_fall &&
                (r_wdog == WDOG_W'(WDOG_LIMIT - 1));
  end

  // --------------------------------------------------------------------------
  // Shift register, bit counter, parity capture
  // --------------------------------------------------------------------------
  always_ff @(posedge iClk or negedge iReset) begin
    if (!iReset) begin
      r_shift   <= 8'h00;
      r_bit_cnt <= 3'd0;
      r_parity  <= 1'b0;
    end else begin
      if (w_start_bit) begin
        r_bit_cnt <= 3'd0;
      end
      if (w_shift_en) begin
        r_shift   <= {w_ps2dat, r_shift[7:1]};
        r_bit_cnt <= r_bit_cnt + 3'd1;
      end
      if (w_par_en) begin
        r_parity <= w_ps2dat;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Watchdog: counts cycles inside a frame, cleared by every falling edge
  // --------------------------------------------------------------------------
  always_ff @(posedge iClk or negedge iReset) begin
    if (!iReset) begin
      r_wdog <= '0;
    end else if ((r_state == ST_IDLE) || w_fall || w_timeout) begin
      r_wdog <= '0;
    end else begin
      r_wdog <= r_wdog + 1'b1;
    end
  end

  // --------------------------------------------------------------------------
  // Frame check at the stop edge
  // --------------------------------------------------------------------------
  logic       w_frame_ok;
  logic       w_frame_bad;
  logic       r_frame_good;
  logic [7:0] r_frame_byte;
  logic       r_frame_err;

  // Odd parity: data bits plus parity bit must contain an odd number of ones.
  assign w_frame_ok  = w_stop_en & w_ps2dat & (^{r_shift, r_parity});
  assign w_frame_bad = (w_stop_en & ~w_frame_ok) | w_timeout;

  always_ff @(posedge iClk or negedge iReset) begin
    if (!iReset) begin
      r_frame_good <= 1'b0;
      r_frame_byte <= 8'h00;
      r_frame_err  <= 1'b0;
    end else begin
      r_frame_good <= w_frame_ok;
      r_frame_err  <= w_frame_bad;
      if (w_stop_en) begin
        r_frame_byte <= r_shift;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Prefix tracking and code output registers
  // --------------------------------------------------------------------------
  logic       r_ext_flag;
  logic       r_brk_flag;
  logic [7:0] r_scan_code;
  logic       r_code_valid;
  logic       r_break;
  logic       r_extended;
  logic       w_code_now;

  assign w_code_now = r_frame_good && (r_frame_byte != CODE_EXT) &&
                      (r_frame_byte != CODE_BRK);

  always_ff @(posedge iClk or negedge iReset) begin
    if (!iReset) begin
      r_ext_flag   <= 1'b0;
      r_brk_flag   <= 1'b0;
      r_scan_code  <= 8'h00;
      r_code_valid <= 1'b0;
      r_break      <= 1'b0;
      r_extended   <= 1'b0;
    end else begin
      r_code_valid <= 1'b0;
      if (w_frame_bad) begin
        // A corrupted frame may have been part of a multi-byte sequence.
        r_ext_flag <= 1'b0;
        r_brk_flag <= 1'b0;
      end else if (r_frame_good) begin
        if (r_frame_byte == CODE_EXT) begin
          r_ext_flag <= 1'b1;
        end else if (r_frame_byte == CODE_BRK) begin
          r_brk_flag <= 1'b1;
        end else begin
          r_scan_code  <= r_frame_byte;
          r_code_valid <= 1'b1;
          r_break      <= r_brk_flag;
          r_extended   <= r_ext_flag;
          r_ext_flag   <= 1'b0;
          r_brk_flag   <= 1'b0;
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // Player control levels and start pulse
  // --------------------------------------------------------------------------
  logic w_left_hit;
  logic w_right_hit;
  logic w_start_hit;

`ifdef PS2_ARROWS_EN
  assign w_left_hit  = (!r_ext_flag && (r_frame_byte == KEY_LEFT)) ||
                       ( r_ext_flag && (r_frame_byte == ARROW_LEFT));
  assign w_right_hit = (!r_ext_flag && (r_frame_byte == KEY_RIGHT)) ||
                       ( r_ext_flag && (r_frame_byte == ARROW_RIGHT));
`else
  assign w_left_hit  = !r_ext_flag && (r_frame_byte == KEY_LEFT);
  assign w_right_hit = !r_ext_flag && (r_frame_byte == KEY_RIGHT);
`endif
  assign w_start_hit = !r_ext_flag && (r_frame_byte == KEY_START);

  logic r_izquierda;
  logic r_derecha;
  logic r_start;
  logic r_start_held;

  always_ff @(posedge iClk or negedge iReset) begin
    if (!iReset) begin
      r_izquierda  <= 1'b0;
      r_derecha    <= 1'b0;
      r_start      <= 1'b0;
      r_start_held <= 1'b0;
    end else begin
      r_start <= 1'b0;
      if (w_code_now) begin
        // Make sets, break clears; typematic repeats simply re-set the level.
        if (w_left_hit) begin
          r_izquierda <= ~r_brk_flag;
        end
        if (w_right_hit) begin
          r_derecha <= ~r_brk_flag;
        end
        if (w_start_hit) begin
          if (r_brk_flag) begin
            r_start_held <= 1'b0;
          end else if (!r_start_held) begin
            r_start      <= 1'b1;
            r_start_held <= 1'b1;
          end
        end
      end
    end
  end

  assign oScanCode  = r_scan_code;
  assign oCodeValid = r_code_valid;
  assign oBreak     = r_break;
  assign oExtended  = r_extended;
  assign oIzquierda = r_izquierda;
  assign oDerecha   = r_derecha;
  assign oStart     = r_start;
  assign oFrameErr  = r_frame_err;

endmodule

// File: tb/tb_ps2_teclado_rx.sv
// ----------------------------------------------------------------------------
// tb_ps2_teclado_rx
//
// Directed bench for ps2_teclado_rx. A PS/2 device model drives the raw lines
// on the falling system-clock edge; a monitor counts output pulses (sampled on
// the falling edge) and the main sequence compares counts and levels against
// hand-computed expectations. Build with PS2_ARROWS_EN to also exercise the
// arrow-key mapping.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_ps2_teclado_rx;

  localparam int HALF = 8;   // system clocks per PS/2 half bit
  localparam int GAP  = 12;  // idle clocks after each frame

  logic       iClk;
  logic       iReset;
  logic       iPs2Clk;
  logic       iPs2Data;
  logic [7:0] oScanCode;
  logic       oCodeValid;
  logic       oBreak;
  logic       oExtended;
  logic       oIzquierda;
  logic       oDerecha;
  logic       oStart;
  logic       oFrameErr;

  ps2_teclado_rx dut (
    .iClk       (iClk),
    .iReset     (iReset),
    .iPs2Clk    (iPs2Clk),
    .iPs2Data   (iPs2Data),
    .oScanCode  (oScanCode),
    .oCodeValid (oCodeValid),
    .oBreak     (oBreak),
    .oExtended  (oExtended),
    .oIzquierda (oIzquierda),
    .oDerecha   (oDerecha),
    .oStart     (oStart),
    .oFrameErr  (oFrameErr)
  );

  initial iClk = 1'b0;
  always #10 iClk = ~iClk;

  int n_checks = 0;
  int n_fail   = 0;

  // Pulse monitor: counts high cycles, so a stretched pulse is also caught.
  int         cv_cnt  = 0;
  int         err_cnt = 0;
  int         st_cnt  = 0;
  logic       last_brk = 1'b0;
  logic       last_ext = 1'b0;
  logic [7:0] last_code = 8'h00;

  always @(negedge iClk) begin
    if (oCodeValid === 1'b1) begin
      cv_cnt    = cv_cnt + 1;
      last_brk  = oBreak;
      last_ext  = oExtended;
      last_code = oScanCode;
    end
    if (oFrameErr === 1'b1) err_cnt = err_cnt + 1;
    if (oStart === 1'b1)    st_cnt  = st_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic ps2_bit(input logic d);
    iPs2Data = d;
    repeat (HALF) @(negedge iClk);
    iPs2Clk = 1'b0;
    repeat (HALF) @(negedge iClk);
    iPs2Clk = 1'b1;
  endtask

  task automatic ps2_frame(input logic [7:0] b, input logic par, input logic stp);
    ps2_bit(1'b0);
    for (int i = 0; i < 8; i++) ps2_bit(b[i]);
    ps2_bit(par);
    ps2_bit(stp);
    iPs2Data = 1'b1;
    repeat (GAP) @(negedge iClk);
  endtask

  // Good frame: odd parity bit chosen so data+parity has an odd count of ones.
  task automatic good_frame(input logic [7:0] b);
    ps2_frame(b, ~^b, 1'b1);
  endtask

  int cycles;

  initial begin
    iReset   = 1'b0;
    iPs2Clk  = 1'b1;
    iPs2Data = 1'b1;
    repeat (3) @(negedge iClk);

    // Reset state
    chk("rst_outputs", {oScanCode, oCodeValid, oBreak, oExtended, oIzquierda,
                        oDerecha, oStart, oFrameErr}, 32'h0);
    iReset = 1'b1;
    repeat (5) @(negedge iClk);

    // 1) 1C, parity 0, stop 1, with exact 4-cycle latency from the stop edge
    ps2_bit(1'b0);
    for (int i = 0; i < 8; i++) begin
      logic [7:0] b1c;
      b1c = 8'h1C;
      ps2_bit(b1c[i]);
    end
    ps2_bit(1'b0);
    iPs2Data = 1'b1;
    repeat (HALF) @(negedge iClk);
    iPs2Clk = 1'b0;
    repeat (3) @(negedge iClk);
    chk("t1_valid_early", oCodeValid, 1'b0);
    @(negedge iClk);
    chk("t1_valid_lat4", oCodeValid, 1'b1);
    chk("t1_code", oScanCode, 8'h1C);
    chk("t1_brk_ext", {oBreak, oExtended}, 2'b00);
    @(negedge iClk);
    chk("t1_valid_1cyc", oCodeValid, 1'b0);
    repeat (HALF) @(negedge iClk);
    iPs2Clk = 1'b1;
    repeat (GAP) @(negedge iClk);
    chk("t1_izq", oIzquierda, 1'b1);

    // 2) F0 1C: no pulse after F0, one break pulse, left released
    good_frame(8'hF0);
    chk("t2_no_pulse_f0", cv_cnt, 1);
    good_frame(8'h1C);
    chk("t2_cv_cnt", cv_cnt, 2);
    chk("t2_break", {last_brk, last_ext, last_code}, {1'b1, 1'b0, 8'h1C});
    chk("t2_izq_low", oIzquierda, 1'b0);

    // 3) 23 with wrong parity, then bad stop bit, then a good 23
    ps2_frame(8'h23, 1'b1, 1'b1);
    chk("t3_err_par", err_cnt, 1);
    chk("t3_no_cv", cv_cnt, 2);
    chk("t3_der_low", oDerecha, 1'b0);
    ps2_frame(8'h1C, 1'b0, 1'b0);
    chk("t3_err_stop", err_cnt, 2);
    chk("t3_izq_still_low", oIzquierda, 1'b0);
    good_frame(8'h23);
    chk("t3_der_high", oDerecha, 1'b1);
    chk("t3_cv_cnt", cv_cnt, 3);

    // 4) space x3, F0 29, 29 -> two start pulses, five code pulses
    good_frame(8'h29);
    chk("t4_start_first", st_cnt, 1);
    good_frame(8'h29);
    good_frame(8'h29);
    chk("t4_no_repeat", st_cnt, 1);
    good_frame(8'hF0);
    good_frame(8'h29);
    good_frame(8'h29);
    chk("t4_start_total", st_cnt, 2);
    chk("t4_cv_cnt", cv_cnt, 8);
    chk("t4_levels_kept", {oIzquierda, oDerecha}, 2'b01);

    // 5) watchdog: 5 bits then clock held high. Raw edge to pulse includes
    //    the two synchroniser stages and the edge register.
    for (int i = 0; i < 4; i++) ps2_bit(1'b0);
    iPs2Data = 1'b1;
    repeat (HALF) @(negedge iClk);
    iPs2Clk = 1'b0;
    cycles = 0;
    repeat (HALF) begin
      @(negedge iClk);
      cycles++;
    end
    iPs2Clk = 1'b1;
    while (oFrameErr !== 1'b1 && cycles < 60000) begin
      @(negedge iClk);
      cycles++;
    end
    chk("t5_timeout_seen", oFrameErr, 1'b1);
    chk("t5_timeout_cycle", (cycles >= 49999 && cycles <= 50006), 1'b1);
    repeat (GAP) @(negedge iClk);
    chk("t5_err_cnt", err_cnt, 3);
    good_frame(8'h1C);
    chk("t5_recover", {last_brk, last_ext, last_code}, {1'b0, 1'b0, 8'h1C});
    chk("t5_cv_cnt", cv_cnt, 9);
    chk("t5_izq", oIzquierda, 1'b1);

    // 6) reset mid-frame while left is held
    ps2_bit(1'b0);
    ps2_bit(1'b1);
    ps2_bit(1'b0);
    iReset = 1'b0;
    #1;
    chk("t6_rst_async", {oScanCode, oCodeValid, oBreak, oExtended, oIzquierda,
                         oDerecha, oStart, oFrameErr}, 32'h0);
    repeat (4) @(negedge iClk);
    iReset = 1'b1;
    iPs2Data = 1'b1;
    repeat (GAP) @(negedge iClk);
    chk("t6_no_err", err_cnt, 3);

    // Extended left arrow: level only with the arrow mapping built in
    good_frame(8'hE0);
    good_frame(8'h6B);
    chk("t6_ext_code", {last_brk, last_ext, last_code}, {1'b0, 1'b1, 8'h6B});
`ifdef PS2_ARROWS_EN
    chk("t6_arrow_make", oIzquierda, 1'b1);
`else
    chk("t6_arrow_make", oIzquierda, 1'b0);
`endif
    good_frame(8'hE0);
    good_frame(8'hF0);
    good_frame(8'h6B);
    chk("t6_ext_break", {last_brk, last_ext}, 2'b11);
    chk("t6_arrow_break", oIzquierda, 1'b0);

    // Extended code equal to KEY_LEFT must not touch the level
    good_frame(8'h1C);
    chk("t6_left_again", oIzquierda, 1'b1);
    good_frame(8'hE0);
    good_frame(8'hF0);
    good_frame(8'h1C);
    chk("t6_ext_1c_ignored", oIzquierda, 1'b1);
    chk("t6_cv_cnt", cv_cnt, 13);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
